// File: rtl/control_decode_pkg.sv
// rtl/control_decode_pkg.sv - shared opcodes, control bit indices and FSM state type
package control_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int CTL_SALTOINCOND = 9;
  localparam int CTL_REGDEST     = 8;
  localparam int CTL_FUENTEALU   = 7;
  localparam int CTL_MEMAREG     = 6;
  localparam int CTL_ESCRREG     = 5;
  localparam int CTL_LEERMEM     = 4;
  localparam int CTL_ESCRMEM     = 3;
  localparam int CTL_SALTOCOND   = 2;
  localparam int CTL_ALUOP_MSB   = 1;
  localparam int CTL_ALUOP_LSB   = 0;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/control_decode_opcode_decoder.sv
// rtl/control_decode_opcode_decoder.sv - purely combinational opcode to control word table
module opcode_decoder
  import control_decode_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [9:0] control,
  output logic       illegal
);

  // Decode table; unsupported opcodes yield an all-zero word and flag illegal
  always_comb begin
    control = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        control[CTL_REGDEST] = 1'b1;
        control[CTL_ESCRREG] = 1'b1;
        control[CTL_ALUOP_MSB:CTL_ALUOP_LSB] = ALUOP_RTYPE;
      end
      OP_LW: begin
        control[CTL_FUENTEALU] = 1'b1;
        control[CTL_MEMAREG]   = 1'b1;
        control[CTL_ESCRREG]   = 1'b1;
        control[CTL_LEERMEM]   = 1'b1;
        control[CTL_ALUOP_MSB:CTL_ALUOP_LSB] = ALUOP_MEM;
      end
      OP_SW: begin
        control[CTL_FUENTEALU] = 1'b1;
        control[CTL_ESCRMEM]   = 1'b1;
        control[CTL_ALUOP_MSB:CTL_ALUOP_LSB] = ALUOP_MEM;
      end
      OP_BEQ: begin
        control[CTL_SALTOCOND] = 1'b1;
        control[CTL_ALUOP_MSB:CTL_ALUOP_LSB] = ALUOP_BRANCH;
      end
      OP_ADDI: begin
        control[CTL_FUENTEALU] = 1'b1;
        control[CTL_ESCRREG]   = 1'b1;
        control[CTL_ALUOP_MSB:CTL_ALUOP_LSB] = ALUOP_MEM;
      end
      OP_J: begin
        control[CTL_SALTOINCOND] = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_decode.sv
// rtl/control_decode.sv - ID-stage control decode with load-use stall FSM and stall counter
module control_decode
  import control_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Flush,
  output logic [9:0]  Control,
  output logic        PCEscr,
  output logic        IFIDEscr,
  output logic        Illegal,
  output logic [15:0] StallCnt
);

  state_t      state;
  state_t      state_next;
  logic        ex_load;
  logic [4:0]  ex_rt;
  logic [15:0] stall_cnt;
  logic [9:0]  dec_control;
  logic        dec_illegal;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hazard;
  logic        stall;
  logic        unused_imm;

  assign rs         = Instr[25:21];
  assign rt         = Instr[20:16];
  assign unused_imm = ^Instr[15:0];
  assign StallCnt   = stall_cnt;

  opcode_decoder u_opcode_decoder (
    .opcode  (Instr[31:26]),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  // A load issued last cycle whose destination (non-$0) is read now needs one bubble
  assign hazard = ex_load & (ex_rt != 5'd0) & ((ex_rt == rs) | (ex_rt == rt));

  // Next state and issued outputs; a flush squashes the word and cancels any stall
  always_comb begin
    state_next = RUN;
    Control    = dec_control;
    Illegal    = dec_illegal;
    PCEscr     = 1'b1;
    IFIDEscr   = 1'b1;
    stall      = 1'b0;
    if (Flush) begin
      Control    = '0;
      Illegal    = 1'b0;
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall      = 1'b1;
            Control    = '0;
            Illegal    = 1'b0;
            PCEscr     = 1'b0;
            IFIDEscr   = 1'b0;
            state_next = STALL;
          end
        end
        STALL: begin
          state_next = RUN;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Shadow of the word actually issued; bubbles and flushes carry LeerMem=0
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_load <= 1'b0;
      ex_rt   <= 5'd0;
    end else begin
      ex_load <= Control[CTL_LEERMEM];
      ex_rt   <= rt;
    end
  end

  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_control_decode.sv
// tb/tb_control_decode.sv - randomized and directed self-checking bench for control_decode
module tb_control_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'd0;
  logic        Flush = 1'b0;
  logic [9:0]  Control;
  logic        PCEscr;
  logic        IFIDEscr;
  logic        Illegal;
  logic [15:0] StallCnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: what was issued last cycle, and the stall tally
  logic        m_load = 1'b0;
  logic [4:0]  m_rt   = 5'd0;
  logic [15:0] m_cnt  = 16'd0;

  control_decode dut (
    .clk      (clk),
    .reset    (reset),
    .Instr    (Instr),
    .Flush    (Flush),
    .Control  (Control),
    .PCEscr   (PCEscr),
    .IFIDEscr (IFIDEscr),
    .Illegal  (Illegal),
    .StallCnt (StallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // {illegal, control} straight from the decode table
  function automatic logic [10:0] ref_decode(input logic [5:0] op);
    case (op)
      6'd0:    return {1'b0, 10'h100 | 10'h020 | 10'h002};
      6'd35:   return {1'b0, 10'h080 | 10'h040 | 10'h020 | 10'h010};
      6'd43:   return {1'b0, 10'h080 | 10'h008};
      6'd4:    return {1'b0, 10'h004 | 10'h001};
      6'd8:    return {1'b0, 10'h080 | 10'h020};
      6'd2:    return {1'b0, 10'h200};
      default: return {1'b1, 10'h000};
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    logic [10:0] d;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        m_stall;
    logic [9:0]  e_ctrl;
    logic        e_ill;
    if (reset) begin
      m_load = 1'b0;
      m_rt   = 5'd0;
      m_cnt  = 16'd0;
    end else begin
      rs = Instr[25:21];
      rt = Instr[20:16];
      d  = ref_decode(Instr[31:26]);
      m_stall = !Flush && m_load && (m_rt != 5'd0) && ((m_rt == rs) || (m_rt == rt));
      e_ctrl  = (Flush || m_stall) ? 10'd0 : d[9:0];
      e_ill   = (Flush || m_stall) ? 1'b0 : d[10];
      chk("model_control", {22'd0, Control}, {22'd0, e_ctrl});
      chk("model_illegal", {31'd0, Illegal}, {31'd0, e_ill});
      chk("model_pcescr", {31'd0, PCEscr}, {31'd0, !m_stall});
      chk("model_ifidescr", {31'd0, IFIDEscr}, {31'd0, !m_stall});
      chk("model_stallcnt", {16'd0, StallCnt}, {16'd0, m_cnt});
      m_load = e_ctrl[4];
      m_rt   = rt;
      if (m_stall && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    end
  end

  task automatic step(input logic [31:0] i, input logic f, input logic r);
    @(posedge clk);
    #1;
    Instr = i;
    Flush = f;
    reset = r;
  endtask

  localparam logic [31:0] LW8    = 32'h8C080000;
  localparam logic [31:0] ADD    = 32'h01094820;
  localparam logic [31:0] LW0    = 32'h8C000000;
  localparam logic [31:0] ADD0   = 32'h00004820;
  localparam logic [31:0] BADOP  = 32'hFC000000;
  localparam logic [31:0] JMP    = 32'h08000010;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [8];
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b1);

    // load followed by dependent add: one bubble, then the add issues
    step(LW8, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_pcescr", {31'd0, PCEscr}, 32'd1);
    chk("rst_stallcnt", {16'd0, StallCnt}, 32'd0);
    chk("lw_control", {22'd0, Control}, 32'h0F0);
    step(ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_control", {22'd0, Control}, 32'd0);
    chk("stall_pcescr", {31'd0, PCEscr}, 32'd0);
    chk("stall_ifidescr", {31'd0, IFIDEscr}, 32'd0);
    step(ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_stall_control", {22'd0, Control}, 32'h122);
    chk("post_stall_pcescr", {31'd0, PCEscr}, 32'd1);
    chk("stallcnt_one", {16'd0, StallCnt}, 32'd1);

    // load into $0 never stalls
    step(LW0, 1'b0, 1'b0);
    step(ADD0, 1'b0, 1'b0);
    @(negedge clk);
    chk("r0_pcescr", {31'd0, PCEscr}, 32'd1);
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("r0_stallcnt", {16'd0, StallCnt}, 32'd1);

    // flush beats hazard
    step(LW8, 1'b0, 1'b0);
    step(ADD, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_control", {22'd0, Control}, 32'd0);
    chk("flush_pcescr", {31'd0, PCEscr}, 32'd1);
    step(ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_flush_pcescr", {31'd0, PCEscr}, 32'd1);
    chk("after_flush_stallcnt", {16'd0, StallCnt}, 32'd1);

    // illegal opcode and jump
    step(BADOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("illegal_flag", {31'd0, Illegal}, 32'd1);
    chk("illegal_control", {22'd0, Control}, 32'd0);
    chk("illegal_pcescr", {31'd0, PCEscr}, 32'd1);
    step(JMP, 1'b0, 1'b0);
    @(negedge clk);
    chk("j_control", {22'd0, Control}, 32'h200);

    // reset taken while in STALL
    step(LW8, 1'b0, 1'b0);
    step(ADD, 1'b0, 1'b0);
    step(ADD, 1'b0, 1'b1);
    step(ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_stall_pcescr", {31'd0, PCEscr}, 32'd1);
    chk("rst_stall_stallcnt", {16'd0, StallCnt}, 32'd0);
    chk("rst_stall_control", {22'd0, Control}, 32'h122);

    // counter saturation from a preloaded value
    step(32'd0, 1'b0, 1'b0);
    #1;
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    m_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      step(LW8, 1'b0, 1'b0);
      step(ADD, 1'b0, 1'b0);
      step(ADD, 1'b0, 1'b0);
    end
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_stallcnt", {16'd0, StallCnt}, 32'h0000FFFF);
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b0);

    // randomized traffic with small register numbers to provoke hazards
    ops[0] = 6'd0;  ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4;
    ops[4] = 6'd8;  ops[5] = 6'd2;  ops[6] = 6'd35; ops[7] = 6'd0;
    for (int n = 0; n < 3000; n++) begin
      logic [5:0]  op;
      logic [31:0] w;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      w = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      step(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
    end
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
